// File: rtl/fft_pkg.sv
// Shared constants and beat types for the FFT post-processing blocks.
`timescale 1ns/1ps
package fft_pkg;
  localparam int FFT_N    = 16;
  localparam int SAMPLE_W = 16;
  localparam int PWR_W    = 32;
  localparam int RE_MSB   = 31;
  localparam int IM_MSB   = 15;

  typedef struct packed {
    logic             last;
    logic [PWR_W-1:0] pwr;
  } pwr_beat_t;
endpackage

// File: rtl/fft_pwr_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
`timescale 1ns/1ps
module fft_pwr_fifo #(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/fft_pwr_peak.sv
// Per-bin power of FFT output frames, buffered with backpressure, plus
// per-frame peak bin/power report and sticky overflow / frame-length flags.
`timescale 1ns/1ps
module fft_pwr_peak
  import fft_pkg::*;
#(
  parameter int FRAME_LEN  = FFT_N,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  S_AXIS_tdata,
  input  logic                         S_AXIS_tvalid,
  input  logic [3:0]                   S_AXIS_tkeep,
  input  logic                         S_AXIS_tlast,
  output logic                         S_AXIS_tready,
  output logic [PWR_W-1:0]             M_AXIS_tdata,
  output logic                         M_AXIS_tvalid,
  output logic [3:0]                   M_AXIS_tkeep,
  output logic                         M_AXIS_tlast,
  input  logic                         M_AXIS_tready,
  output logic                         Peak_valid,
  output logic [$clog2(FRAME_LEN)-1:0] Peak_bin,
  output logic [PWR_W-1:0]             Peak_pwr,
  output logic                         Overflow,
  output logic                         Frame_err,
  input  logic                         Clr_err,
  output logic                         Busy
);
  localparam int STAGES = 2;
  localparam int BW     = $clog2(FRAME_LEN);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int SQ_W   = 2*SAMPLE_W - 1;
  localparam logic [BW-1:0] LAST_BIN = BW'(FRAME_LEN-1);

  logic [STAGES:1]   vld_pipe;
  logic              acc, ovf_ev, ferr_ev, pop;
  logic [CW:0]       occ;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  pwr_beat_t         push_beat, head;

  logic signed [31:0] re_x, im_x, re_p, im_p;
  logic [SQ_W-1:0]    re_sq, im_sq;
  logic               last1, last2;
  logic [PWR_W-1:0]   pwr2;

  logic [BW-1:0]      bin_cnt, max_idx, nxt_idx;
  logic [PWR_W-1:0]   max_pwr, nxt_pwr;
  logic               take;

  // Count beats already in flight so a push can never hit a full FIFO.
  assign occ = {1'b0, fifo_count} + {{CW{1'b0}}, vld_pipe[1]} + {{CW{1'b0}}, vld_pipe[2]};
  assign S_AXIS_tready = !rst && (occ < (CW+1)'(FIFO_DEPTH));
  assign acc    = S_AXIS_tvalid && S_AXIS_tready;
  assign ovf_ev = S_AXIS_tvalid && !S_AXIS_tready;

  assign re_x = {{(32-SAMPLE_W){S_AXIS_tdata[RE_MSB]}}, S_AXIS_tdata[RE_MSB -: SAMPLE_W]};
  assign im_x = {{(32-SAMPLE_W){S_AXIS_tdata[IM_MSB]}}, S_AXIS_tdata[IM_MSB -: SAMPLE_W]};
  assign re_p = re_x * re_x;
  assign im_p = im_x * im_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      re_sq    <= '0;
      im_sq    <= '0;
      last1    <= 1'b0;
      pwr2     <= '0;
      last2    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      re_sq    <= re_p[SQ_W-1:0];
      im_sq    <= im_p[SQ_W-1:0];
      last1    <= S_AXIS_tlast;
      pwr2     <= {1'b0, re_sq} + {1'b0, im_sq};
      last2    <= last1;
    end
  end

  // Bin 0 always loads; strict compare keeps the lowest index on ties.
  assign take    = (bin_cnt == '0) || (pwr2 > max_pwr);
  assign nxt_pwr = take ? pwr2 : max_pwr;
  assign nxt_idx = take ? bin_cnt : max_idx;
  assign ferr_ev = vld_pipe[2] && (last2 ? (bin_cnt != LAST_BIN) : (bin_cnt == LAST_BIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt    <= '0;
      max_idx    <= '0;
      max_pwr    <= '0;
      Peak_valid <= 1'b0;
      Peak_bin   <= '0;
      Peak_pwr   <= '0;
      Overflow   <= 1'b0;
      Frame_err  <= 1'b0;
    end else begin
      Peak_valid <= 1'b0;
      if (vld_pipe[2]) begin
        max_idx <= nxt_idx;
        max_pwr <= nxt_pwr;
        if (last2) begin
          Peak_bin   <= nxt_idx;
          Peak_pwr   <= nxt_pwr;
          Peak_valid <= 1'b1;
          bin_cnt    <= '0;
        end else if (bin_cnt == LAST_BIN) begin
          bin_cnt <= '0;
        end else begin
          bin_cnt <= bin_cnt + 1'b1;
        end
      end
      Overflow  <= ovf_ev  || (Overflow  && !Clr_err);
      Frame_err <= ferr_ev || (Frame_err && !Clr_err);
    end
  end

  assign push_beat = '{last: last2, pwr: pwr2};
  assign pop       = M_AXIS_tvalid && M_AXIS_tready;

  fft_pwr_fifo #(.WIDTH($bits(pwr_beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[2]),
    .pop   (pop),
    .din   (push_beat),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Stale RAM contents stay hidden while the FIFO is empty.
  assign M_AXIS_tvalid = !fifo_empty;
  assign M_AXIS_tdata  = fifo_empty ? '0 : head.pwr;
  assign M_AXIS_tlast  = !fifo_empty && head.last;
  assign M_AXIS_tkeep  = 4'hf;
  assign Busy          = |vld_pipe || !fifo_empty;

  logic unused_ok;
  assign unused_ok = ^{S_AXIS_tkeep, fifo_full, re_p[31], im_p[31]};
endmodule

// File: tb/tb_fft_pwr_peak.sv
// Scoreboard bench for fft_pwr_peak: driver queues expected beats/peaks,
// a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_fft_pwr_peak;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] S_AXIS_tdata = '0;
  logic        S_AXIS_tvalid = 1'b0, S_AXIS_tlast = 1'b0, S_AXIS_tready;
  logic [3:0]  S_AXIS_tkeep = 4'h0, M_AXIS_tkeep;
  logic [31:0] M_AXIS_tdata, Peak_pwr;
  logic        M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tready = 1'b1;
  logic        Peak_valid, Overflow, Frame_err, Clr_err = 1'b0, Busy;
  logic [3:0]  Peak_bin;

  fft_pwr_peak #(.FRAME_LEN(16), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tkeep(S_AXIS_tkeep),
    .S_AXIS_tlast(S_AXIS_tlast), .S_AXIS_tready(S_AXIS_tready),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tkeep(M_AXIS_tkeep),
    .M_AXIS_tlast(M_AXIS_tlast), .M_AXIS_tready(M_AXIS_tready),
    .Peak_valid(Peak_valid), .Peak_bin(Peak_bin), .Peak_pwr(Peak_pwr),
    .Overflow(Overflow), .Frame_err(Frame_err), .Clr_err(Clr_err), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int bin; logic [31:0] pwr; int at; } pk_t;
  logic [32:0] exp_q[$];
  pk_t         pk_q[$];
  int          checks = 0, errors = 0;
  int          fr_re[16], fr_im[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && M_AXIS_tvalid && M_AXIS_tready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL m_beat_unexpected: got %0h expected none", M_AXIS_tdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("m_tdata", M_AXIS_tdata, e[31:0]);
        chk("m_tlast", M_AXIS_tlast, e[32]);
        chk("m_tkeep", M_AXIS_tkeep, 4'hf);
      end
    end
    if (!rst && Peak_valid) begin
      if (pk_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL peak_unexpected: got bin %0d pwr %0h expected none", Peak_bin, Peak_pwr);
      end else begin
        pk_t p;
        p = pk_q.pop_front();
        chk("peak_bin", Peak_bin, p.bin);
        chk("peak_pwr", Peak_pwr, p.pwr);
        chk("peak_cycle", cyc, p.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_frame();
    for (int i = 0; i < 16; i++) begin fr_re[i] = 0; fr_im[i] = 0; end
  endtask

  task automatic send_beat(input int re, input int im, input bit last, output bit acc);
    longint p;
    S_AXIS_tdata  = {re[15:0], im[15:0]};
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tlast  = last;
    #1;
    acc = S_AXIS_tready;
    p = longint'(re) * re + longint'(im) * im;
    if (acc) exp_q.push_back({last, p[31:0]});
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int n, input int pb, input logic [31:0] pp);
    bit acc;
    int at;
    for (int i = 0; i < n; i++) begin
      at = cyc;
      send_beat(fr_re[i], fr_im[i], i == n-1, acc);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL beat_accept: got dropped expected accepted (bin %0d)", i);
      end
      if (i == n-1 && acc) pk_q.push_back('{pb, pp, at + 3});
    end
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tlast  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!Busy && exp_q.size() == 0 && pk_q.size() == 0) break;
      tick();
    end
    chk("idle_timeout", {Busy, exp_q.size() != 0, pk_q.size() != 0}, 0);
  endtask

  initial begin
    bit acc;
    repeat (3) tick();
    // reset state
    chk("rst_m_tvalid", M_AXIS_tvalid, 0);
    chk("rst_m_tdata", M_AXIS_tdata, 0);
    chk("rst_s_tready", S_AXIS_tready, 0);
    chk("rst_flags", {Peak_valid, Overflow, Frame_err, Busy}, 0);
    chk("rst_peak", {Peak_bin, Peak_pwr}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_tready", S_AXIS_tready, 1);
    tick();

    // 1: single peak at bin 5
    clr_frame(); fr_re[5] = 100;
    send_frame(16, 5, 32'd10000);
    wait_idle();
    // 2: most negative corner, sum reaches 2^31
    clr_frame(); fr_re[0] = -32768; fr_im[0] = -32768;
    send_frame(16, 0, 32'h8000_0000);
    wait_idle();
    // 3: tie resolves to lowest index
    clr_frame(); fr_re[2] = 20; fr_re[9] = 20;
    send_frame(16, 2, 32'd400);
    wait_idle();
    chk("flags_clean", {Overflow, Frame_err}, 0);

    // 4: backpressure, 32 beats fit, 33rd dropped
    M_AXIS_tready = 1'b0;
    clr_frame(); fr_re[3] = 300; fr_im[3] = 400;
    send_frame(16, 3, 32'd250000);
    clr_frame(); fr_re[15] = -7; fr_im[15] = 24;
    send_frame(16, 15, 32'd625);
    repeat (4) tick();
    chk("bp_no_overflow", Overflow, 0);
    chk("bp_tready_low", S_AXIS_tready, 0);
    send_beat(1, 1, 1'b0, acc);
    S_AXIS_tvalid = 1'b0;
    chk("bp_drop", acc, 0);
    chk("bp_overflow_set", Overflow, 1);
    M_AXIS_tready = 1'b1;
    wait_idle();
    chk("bp_no_frame_err", Frame_err, 0);
    Clr_err = 1'b1; tick(); Clr_err = 1'b0;
    chk("ovf_cleared", Overflow, 0);

    // 5: short frame then normal frame
    clr_frame(); fr_re[4] = 50;
    send_frame(10, 4, 32'd2500);
    wait_idle();
    chk("short_frame_err", Frame_err, 1);
    clr_frame(); fr_re[7] = -3; fr_im[7] = 4;
    send_frame(16, 7, 32'd25);
    wait_idle();
    chk("frame_err_sticky", Frame_err, 1);
    Clr_err = 1'b1; tick(); Clr_err = 1'b0;
    chk("frame_err_cleared", Frame_err, 0);

    // 6: reset mid-frame
    M_AXIS_tready = 1'b0;
    for (int i = 0; i < 7; i++) send_beat(i + 1, 0, 1'b0, acc);
    S_AXIS_tvalid = 1'b0;
    chk("pre_rst_busy", Busy, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_m_tvalid", M_AXIS_tvalid, 0);
    chk("mid_rst_m_tdata", {M_AXIS_tlast, M_AXIS_tdata}, 0);
    chk("mid_rst_flags", {Peak_valid, Overflow, Frame_err, Busy, S_AXIS_tready}, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_tready", S_AXIS_tready, 1);
    M_AXIS_tready = 1'b1;
    tick();
    clr_frame(); fr_re[6] = 9; fr_im[6] = -12;
    send_frame(16, 6, 32'd225);
    wait_idle();
    chk("final_flags", {Overflow, Frame_err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
